// File: rtl/count_mon_pkg.sv
// Shared types for the count-delta rate monitor: FSM state encoding,
// default widths and the packed report record carried through the FIFO.
package count_mon_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int SEQ_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } mon_state_t;

    typedef struct packed {
        logic [SEQ_W_DEF-1:0] seq;
        logic [CNT_W_DEF-1:0] delta;
    } report_t;

endpackage

// File: rtl/count_mon_fifo.sv
// Synchronous report FIFO with a registered head word, exact occupancy and
// push-while-full accepted when a pop happens in the same cycle.
module count_mon_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [LW-1:0] lvl_reg;
    logic [LW-1:0] lvl_next;
    logic [W-1:0]  head_reg;
    logic [W-1:0]  head_next;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (lvl_reg == LW'(DEPTH));
    assign empty   = (lvl_reg == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    assign rd_ptr_next = rd_ptr_reg + AW'(pop_ok);
    assign lvl_next    = lvl_reg + LW'(push_ok) - LW'(pop_ok);

    // When the FIFO drains to zero in this cycle the incoming word becomes the
    // head directly; otherwise the head is read from storage at the new pointer.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (push_ok && (lvl_reg == LW'(pop_ok))) begin
            head_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            lvl_reg    <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            lvl_reg    <= lvl_next;
            head_reg   <= head_next;
        end
    end

    assign dout  = head_reg;
    assign level = lvl_reg;

endmodule

// File: rtl/count_delta_reporter.sv
// Samples an event counter once per WINDOW cycles and streams the modular
// per-window increment, tagged with a window sequence number, over valid/ready.
module count_delta_reporter
    import count_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = 16,
    parameter int DEPTH  = 4,
    parameter int SEQ_W  = SEQ_W_DEF,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CNT_W-1:0]          cnt_in,
    input  logic                      mon_en,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [CNT_W-1:0]          rpt_delta,
    output logic [SEQ_W-1:0]          rpt_seq,
    output logic [DROP_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]    fifo_lvl
);

    localparam int TMR_W = $clog2(WINDOW);
    localparam int RW    = SEQ_W + CNT_W;

    mon_state_t         state_reg;
    mon_state_t         state_next;
    logic [TMR_W-1:0]   timer_reg;
    logic [CNT_W-1:0]   base_reg;
    logic [SEQ_W-1:0]   seq_reg;
    logic [DROP_W-1:0]  drop_reg;

    logic               prime_cap;
    logic               run_active;
    logic               win_close;
    logic               drop;
    logic [CNT_W-1:0]   delta;
    logic [RW-1:0]      fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = ST_IDLE;
        case (state_reg)
            ST_IDLE:  state_next = mon_en ? ST_PRIME : ST_IDLE;
            ST_PRIME: state_next = mon_en ? ST_RUN   : ST_IDLE;
            ST_RUN:   state_next = mon_en ? ST_RUN   : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Dropping mon_en in PRIME or RUN suppresses every action of that cycle,
    // so a partial window never produces a report.
    always_comb begin
        prime_cap  = (state_reg == ST_PRIME) && mon_en;
        run_active = (state_reg == ST_RUN) && mon_en;
        win_close  = run_active && (timer_reg == TMR_W'(WINDOW - 1));
    end

    assign delta = cnt_in - base_reg;
    assign drop  = win_close & fifo_full & ~(rpt_valid & rpt_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_reg <= '0;
            base_reg  <= '0;
            seq_reg   <= '0;
            drop_reg  <= '0;
        end else begin
            if (prime_cap) begin
                base_reg  <= cnt_in;
                timer_reg <= '0;
            end else if (win_close) begin
                base_reg  <= cnt_in;
                timer_reg <= '0;
                seq_reg   <= seq_reg + SEQ_W'(1);
            end else if (run_active) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end
            if (drop && (drop_reg != '1)) begin
                drop_reg <= drop_reg + DROP_W'(1);
            end
        end
    end

    count_mon_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (win_close),
        .din   ({seq_reg, delta}),
        .pop   (rpt_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

    assign rpt_valid = ~fifo_empty;
    assign rpt_seq   = fifo_dout[RW-1:CNT_W];
    assign rpt_delta = fifo_dout[CNT_W-1:0];
    assign drop_cnt  = drop_reg;

endmodule

// File: tb/tb_count_delta_reporter.sv
// Directed bench for count_delta_reporter: stimulus queues hand-computed reports,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_count_delta_reporter;
    import count_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mon_en = 1'b0;
    logic       rpt_ready = 1'b0;
    logic       cnt_en = 1'b0;
    logic [7:0] cnt_in = 8'd0;

    logic       rpt_valid;
    logic [7:0] rpt_delta;
    logic [3:0] rpt_seq;
    logic [7:0] drop_cnt;
    logic [2:0] fifo_lvl;

    int checks = 0;
    int failures = 0;
    report_t exp_q[$];

    logic       hold_v = 1'b0;
    logic [3:0] hold_seq = '0;
    logic [7:0] hold_delta = '0;

    count_delta_reporter #(
        .CNT_W  (8),
        .WINDOW (16),
        .DEPTH  (4),
        .SEQ_W  (4),
        .DROP_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_in    (cnt_in),
        .mon_en    (mon_en),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_delta (rpt_delta),
        .rpt_seq   (rpt_seq),
        .drop_cnt  (drop_cnt),
        .fifo_lvl  (fifo_lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock edge; the model counter advances just after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (cnt_en) cnt_in = cnt_in + 8'd1;
        end
    endtask

    task automatic expect_rpt(input int seq, input int delta);
        report_t r;
        r.seq   = 4'(seq);
        r.delta = 8'(delta);
        exp_q.push_back(r);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        if (!rst_n) hold_v = 1'b0;
    end

    always @(negedge clk) begin
        report_t e;
        if (rst_n) begin
            if (hold_v) begin
                chk("stall_valid", int'(rpt_valid), 1);
                chk("stall_seq", int'(rpt_seq), int'(hold_seq));
                chk("stall_delta", int'(rpt_delta), int'(hold_delta));
            end
            if (rpt_valid && rpt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_report: got seq=%0d delta=%0d, required no report", rpt_seq, rpt_delta);
                end else begin
                    e = exp_q.pop_front();
                    $display("report seq=%0d delta=%0d (expected seq=%0d delta=%0d)", rpt_seq, rpt_delta, e.seq, e.delta);
                    chk("rpt_seq", int'(rpt_seq), int'(e.seq));
                    chk("rpt_delta", int'(rpt_delta), int'(e.delta));
                end
            end
            hold_v     = rpt_valid && !rpt_ready;
            hold_seq   = rpt_seq;
            hold_delta = rpt_delta;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        step(2);
        chk("reset_valid", int'(rpt_valid), 0);
        chk("reset_lvl", int'(fifo_lvl), 0);
        chk("reset_drop", int'(drop_cnt), 0);
        chk("reset_seq", int'(rpt_seq), 0);
        chk("reset_delta", int'(rpt_delta), 0);

        // 1: free-running counter, consumer always ready
        rst_n = 1'b1; cnt_in = 8'd0; cnt_en = 1'b1; mon_en = 1'b1; rpt_ready = 1'b1;
        expect_rpt(0, 16); expect_rpt(1, 16); expect_rpt(2, 16);
        wait_empty("t1_drain", 80);
        mon_en = 1'b0;
        step(1);
        chk("t1_drop", int'(drop_cnt), 0);

        // 2: base 250, ten increments wrapping through zero, then hold
        cnt_en = 1'b0; cnt_in = 8'd250; mon_en = 1'b1;
        expect_rpt(3, 10);
        step(2);
        cnt_en = 1'b1;
        step(10);
        cnt_en = 1'b0;
        wait_empty("t2_drain", 40);
        mon_en = 1'b0;
        step(1);

        // 3: six windows with the consumer stalled
        rpt_ready = 1'b0; cnt_en = 1'b1; mon_en = 1'b1;
        expect_rpt(4, 16); expect_rpt(5, 16); expect_rpt(6, 16); expect_rpt(7, 16);
        expect_rpt(10, 16);
        step(98);
        chk("t3_lvl", int'(fifo_lvl), 4);
        chk("t3_drop", int'(drop_cnt), 2);
        chk("t3_valid", int'(rpt_valid), 1);
        chk("t3_head_seq", int'(rpt_seq), 4);

        // 4: pop lands on the same edge as a full-FIFO window close
        step(15);
        rpt_ready = 1'b1;
        step(1);
        chk("t4_lvl", int'(fifo_lvl), 4);
        chk("t4_drop", int'(drop_cnt), 2);
        mon_en = 1'b0;
        wait_empty("t4_drain", 20);
        chk("t4_lvl_empty", int'(fifo_lvl), 0);

        // 5: mon_en dropped at timer=9 of the second window
        rpt_ready = 1'b0; mon_en = 1'b1;
        expect_rpt(11, 16);
        step(27);
        mon_en = 1'b0;
        step(1);
        chk("t5_lvl_kept", int'(fifo_lvl), 1);
        step(20);
        chk("t5_lvl_idle", int'(fifo_lvl), 1);
        chk("t5_drop", int'(drop_cnt), 2);
        expect_rpt(12, 16);
        mon_en = 1'b1; rpt_ready = 1'b1;
        wait_empty("t5_drain", 60);
        mon_en = 1'b0;
        step(1);

        // 6: reset with three entries queued and the timer mid-window
        rpt_ready = 1'b0; mon_en = 1'b1;
        step(55);
        chk("t6_lvl_pre", int'(fifo_lvl), 3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t6_valid", int'(rpt_valid), 0);
        chk("t6_lvl", int'(fifo_lvl), 0);
        chk("t6_drop", int'(drop_cnt), 0);
        chk("t6_seq", int'(rpt_seq), 0);
        expect_rpt(0, 16);
        rpt_ready = 1'b1;
        wait_empty("t6_drain", 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
